instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the combinational instruction memory (32-bit byte address in, 32-bit word out, indexed by address>>2, 256 words).
- Owns the program counter and drives the memory address from it.
- Registers each returned instruction with its PC into a valid/ready output slot for decode.
- Handles branch/jump redirects with flush, decode backpressure, and out-of-range or misaligned PC faults.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into the PC on reset.
- IMEM_WORDS, 256, number of valid instruction words; PCs with (pc>>2) >= IMEM_WORDS fault.
- NOP_INSTR, 32'h00000013, value placed on out_instr when the slot is empty.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  fetch permitted when high.
- imem_address  output  32  byte address to instruction memory; always equals the pc register.
- imem_instruction  input  32  word returned combinationally for imem_address.
- redirect_valid  input  1  take redirect_target this cycle.
- redirect_target  input  32  new byte PC.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the slot.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  byte PC of out_instr.
- fault  output  1  sticky fault flag.
- fault_pc  output  32  offending PC.
- fetch_count  output  32  number of accepted handshakes (out_valid && out_ready).

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of state or pending handshakes:
  - pc=RESET_PC, out_valid=0, out_instr=NOP_INSTR, out_pc=0, fault=0, fault_pc=0, fetch_count=0, state=IDLE.
- States: IDLE, RUN, FAULT.
- IDLE: out_valid=0. Moves to RUN at the next edge where enable=1. redirect_valid in IDLE still loads pc (subject to the fault check).
- RUN, per edge, in priority order:
  1. redirect_valid=1:
     - Flush: out_valid<=0, out_instr<=NOP_INSTR.
     - If redirect_target[1:0]!=0 or (redirect_target>>2)>=IMEM_WORDS: state<=FAULT, fault<=1, fault_pc<=redirect_target, pc unchanged.
     - Else pc<=redirect_target.
     - A handshake completing this same cycle (out_valid && out_ready) still increments fetch_count; the slot is then flushed.
  2. Hold (out_valid=1 and out_ready=0): pc, out_instr, out_pc, out_valid unchanged.
  3. Fetch (enable=1 and (out_valid=0 or out_ready=1)):
     - If (pc>>2)>=IMEM_WORDS: FAULT, fault_pc<=pc, out_valid<=0.
     - Else out_instr<=imem_instruction, out_pc<=pc, out_valid<=1, pc<=pc+4.
  4. Otherwise (enable=0, slot empty or consumed): out_valid<=0, out_instr<=NOP_INSTR.
- fetch_count increments by 1 on every edge with out_valid && out_ready, in any state except reset. Wraps modulo 2^32.
- FAULT:
  - out_valid=0 and fault=1, held until reset.
  - redirect_valid and enable are ignored.
  - A handshake pending when the fault is entered is dropped (out_valid<=0).
- Throughput: one instruction per cycle with out_ready held high.
- Latency:
  - First fetch edge is the edge after IDLE->RUN; out_valid rises after that edge.
  - Redirect sampled at edge N: target instruction captured at edge N+1, valid from then on. Exactly one bubble.
- PC arithmetic: 32-bit unsigned, wraps. Wrap past IMEM_WORDS is caught by the range check before any fetch.
- imem_address is purely combinational from the pc register: no combinational path from redirect_target or out_ready to imem_address.

Test Plan:
- Reset, enable=1, out_ready=1, memory preloaded with 00a00513, 00100593, 00400313 at words 0-2:
  - out_valid rises two edges after reset release.
  - Stream on successive cycles: (pc 0, 00a00513), (pc 4, 00100593), (pc 8, 00400313).
  - fetch_count=3 after the third handshake.
- Backpressure: out_ready=0 for 3 cycles while holding (pc 4, 00100593):
  - out_* stable, imem_address stays 8, fetch_count unchanged.
  - After out_ready=1, the next slot is (pc 8, 00400313); no skip, no duplicate.
- Redirect while out_valid=1, out_ready=0, redirect_target=32'h20:
  - Slot flushed next cycle (out_valid=0, out_instr=00000013).
  - The following cycle gives (pc 0x20, MI[8]=fe0608e3).
- Misaligned redirect_target=32'h22:
  - fault=1, fault_pc=0x22, out_valid=0.
  - fault stays set for 10 further cycles despite enable=1 and redirects.
  - Cleared only by rst_n=0.
- Run-off with IMEM_WORDS=13:
  - After (pc 0x30, 000000ef) is accepted, the next fetch attempt at pc 0x34 raises fault with fault_pc=0x34.
  - No further out_valid.
- Reset mid-stream (rst_n=0 for one edge with out_valid=1):
  - All outputs return to reset values; pc=RESET_PC.
  - Fetch restarts from 00a00513.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner feeding a combinational imem and a valid/ready slot to decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, opc_q, opc_d, fpc_q, fpc_d, count_q, count_d;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic        pc_oor, tgt_bad;
  assign pc_oor  = {2'b00, pc_q[31:2]} >= LIMIT;
  assign tgt_bad = (redirect_target[1:0] != 2'b00) || ({2'b00, redirect_target[31:2]} >= LIMIT);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    count_d = count_q + {31'b0, valid_q && out_ready};
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        state_d = enable ? RUN : IDLE;
        if (redirect_valid) begin
          if (tgt_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end
      end
      RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (tgt_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end else if (valid_q && !out_ready) begin
          valid_d = 1'b1;
        end else if (enable) begin
          if (pc_oor) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = pc_q;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_instruction;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      opc_q   <= 32'h0;
      fault_q <= 1'b0;
      fpc_q   <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
      count_q <= count_d;
    end
  end
  assign imem_address = pc_q;
  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_pc       = opc_q;
  assign fault        = fault_q;
  assign fault_pc     = fpc_q;
  assign fetch_count  = count_q;
endmodule
